// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and default widths for the unified memory-port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: FSM state enum, requester id enum, latched access-control struct,
// and the default address/data widths used by the interface and the top.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  // Access controls captured at grant time and replayed onto the memory port.
  typedef struct packed {
    logic we;
    logic is_byte;
    logic is_half;
    logic sext;
  } ctl_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles both requester ports and the shared memory port.
// Latency: n/a (wires only).
// Backpressure: level request held by each requester until its one-cycle ack.
//
// Modports:
//   slave  - the arbiter: takes i_*/d_* requests and mem_rdata, drives acks, rdata, mem_*.
//   master - the surrounding system (processor requesters plus dmem).
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  // fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  // load/store requester
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_we;
  logic              d_byte;
  logic              d_half;
  logic              d_sext;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  // shared memory port (combinational read)
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_byte;
  logic              mem_half;
  logic              mem_sext;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_ack, i_rdata,
    input  d_req, d_addr, d_wdata, d_we, d_byte, d_half, d_sext,
    output d_ack, d_rdata,
    output mem_addr, mem_wdata, mem_we, mem_byte, mem_half, mem_sext,
    input  mem_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_ack, i_rdata,
    output d_req, d_addr, d_wdata, d_we, d_byte, d_half, d_sext,
    input  d_ack, d_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_byte, mem_half, mem_sext,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational winner selection between fetch and load/store requests.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the loser simply keeps its level request asserted.
//
// Ports: i_req, d_req (pending requests), last_grant (only with MEM_ARB_RR_EN),
//        grant_vld (any request pending), grant (winning requester id).
// MEM_ARB_RR_EN defined: ties alternate, going to the requester not granted last.
// MEM_ARB_RR_EN undefined: data always beats fetch.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  req_id_t last_grant,
`endif
  input  logic    i_req,
  input  logic    d_req,
  output logic    grant_vld,
  output req_id_t grant
);

  always_comb begin
    grant_vld = i_req | d_req;
    grant     = REQ_D;
`ifdef MEM_ARB_RR_EN
    if (i_req && d_req) begin
      grant = (last_grant == REQ_D) ? REQ_I : REQ_D;
    end else if (i_req) begin
      grant = REQ_I;
    end
`else
    if (i_req && !d_req) begin
      grant = REQ_I;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one dmem port between instruction fetch and load/store.
// Latency: request seen in IDLE at cycle c -> ack at c+LATENCY+1; one access per LATENCY+2 cycles.
// Backpressure: requests are levels held until ack; the non-winner waits, never dropped.
//
// Ports: clock, reset (async, active low), bus (mem_port_arbiter_if.slave) carrying
//        i_req/i_addr/i_ack/i_rdata, d_req/d_addr/d_wdata/d_we/d_byte/d_half/d_sext/
//        d_ack/d_rdata, and mem_addr/mem_wdata/mem_we/mem_byte/mem_half/mem_sext/mem_rdata.
// Optional macro MEM_ARB_RR_EN: round-robin arbitration on ties (default: data over fetch).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
)
(
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  // cnt counts the remaining BUSY cycles; LATENCY=1 still needs a 1-bit counter.
  localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero;
  req_id_t           winner;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  ctl_t              lat_ctl;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              grant_vld;
  req_id_t           grant;
  logic              take_grant;

  assign cnt_zero   = (cnt == '0);
  assign take_grant = (state == IDLE) && grant_vld;

`ifdef MEM_ARB_RR_EN
  req_id_t last_grant;

  // Resets to fetch so the first tie after reset goes to data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= REQ_I;
    end else if (take_grant) begin
      last_grant <= grant;
    end
  end
`endif

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .grant_vld  (grant_vld),
    .grant      (grant)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = BUSY;
      BUSY:    if (cnt_zero)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // The memory port is only driven in BUSY; the write strobe is confined to the
  // final BUSY cycle so each store commits exactly once. A reset mid-access
  // forces IDLE asynchronously, which zeroes every mem_* output before the strobe.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.mem_byte  = 1'b0;
    bus.mem_half  = 1'b0;
    bus.mem_sext  = 1'b0;
    bus.i_ack     = 1'b0;
    bus.d_ack     = 1'b0;
    case (state)
      BUSY: begin
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;
        bus.mem_we    = lat_ctl.we & cnt_zero;
        bus.mem_byte  = lat_ctl.is_byte;
        bus.mem_half  = lat_ctl.is_half;
        bus.mem_sext  = lat_ctl.sext;
      end
      DONE: begin
        bus.i_ack = (winner == REQ_I);
        bus.d_ack = (winner == REQ_D);
      end
      default: ;
    endcase
  end

  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

  // ---------------- access datapath ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      winner    <= REQ_I;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_ctl   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (take_grant) begin
      winner <= grant;
      cnt    <= CNT_LOAD;
      if (grant == REQ_D) begin
        lat_addr  <= bus.d_addr;
        lat_wdata <= bus.d_wdata;
        lat_ctl   <= '{we: bus.d_we, is_byte: bus.d_byte, is_half: bus.d_half, sext: bus.d_sext};
      end else begin
        // Fetches are always plain word reads.
        lat_addr  <= bus.i_addr;
        lat_wdata <= '0;
        lat_ctl   <= '0;
      end
    end else if (state == BUSY) begin
      if (!cnt_zero) begin
        cnt <= cnt - CNT_W'(1);
      end else if (winner == REQ_D) begin
        d_rdata_q <= bus.mem_rdata;
      end else begin
        i_rdata_q <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data-memory port (`dmem`) between the processor's instruction-fetch path and its load/store path, so the multi-cycle processor can run from one unified memory. Each requester holds a level request until it receives a one-cycle acknowledge; the arbiter selects one requester, drives the memory for a configurable access latency, and returns captured read data. It sits between `processor` and `dmem`, replacing the direct memory connections.

## Interface
- `LATENCY`, 1, cycles the memory address/controls are held per access (≥1)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `i_req`  in  1  fetch request, level, held until `i_ack`
- `i_addr`  in  ADDR_W  fetch address
- `i_ack`  out  1  one-cycle fetch completion pulse
- `i_rdata`  out  DATA_W  fetched instruction, valid while `i_ack`=1
- `d_req`  in  1  data request, level, held until `d_ack`
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_we`, `d_byte`, `d_half`, `d_sext`  in  1 each  store enable, byte access, half-word access, sign-extend
- `d_ack`  out  1  one-cycle data completion pulse
- `d_rdata`  out  DATA_W  load data, valid while `d_ack`=1
- `mem_addr`  out  ADDR_W  to `dmem.addr`
- `mem_wdata`  out  DATA_W  to `dmem.data_in`
- `mem_we`, `mem_byte`, `mem_half`, `mem_sext`  out  1 each  to `dmem` controls
- `mem_rdata`  in  DATA_W  from `dmem.data_out` (combinational read)

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: with no request pending, stay. Otherwise pick a winner, latch its address, write data and controls (fetch: `we`/`byte`/`half`/`sext` = 0), load `cnt`=LATENCY-1, and go to BUSY.
- BUSY: drive the latched fields onto `mem_*`. When `cnt`≠0, decrement. When `cnt`=0, assert `mem_we` (only if latched `we`=1), capture `mem_rdata` into the winner's rdata register, and go to DONE.
- DONE: pulse the winner's ack for one cycle, then go to IDLE.
- Arbitration (default): fixed priority, data over fetch.
- A request still high in the IDLE cycle after its ack is a new request. Requesters update the address after ack.
- The non-winner's request stays pending, is never dropped, and its ack stays 0.
- `mem_we` is high for exactly one cycle per store access, so each store commits exactly once.
- In IDLE and DONE, all `mem_*` outputs are 0.
- `i_rdata`/`d_rdata` hold their last captured value until the next capture for that port.

## Timing
- Request seen in IDLE at cycle c → BUSY for cycles c+1..c+LATENCY → ack in cycle c+LATENCY+1 → IDLE at c+LATENCY+2.
- Throughput: one access per LATENCY+2 cycles.
- Reset values: state IDLE, `cnt`=0, `i_ack`=`d_ack`=0, `i_rdata`=`d_rdata`=0, all `mem_*`=0, last-grant = fetch.
- Reset mid-access: all outputs are forced to 0 asynchronously, the in-flight store does not commit, and no ack is issued. Pending requests are re-arbitrated from IDLE after reset releases.
- Simultaneous requests in IDLE: exactly one grant, per the arbitration rule.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - On simultaneous requests, grant the requester not granted last.
  - The last-grant register updates at each grant. It resets to fetch, so the first tie goes to data.
  - A lone requester is always granted.
- `MEM_ARB_RR_EN` undefined: fixed data-over-fetch priority. The last-grant register is not built.

## Structure
- Package `mem_arb_pkg` contains:
  - state enum {IDLE, BUSY, DONE}
  - requester id enum {REQ_I, REQ_D}
  - `ADDR_W`/`DATA_W` default constants
- Sub-module `mem_arb_pick`: combinational winner selection from `i_req`, `d_req` and last-grant. It holds the `MEM_ARB_RR_EN` logic.

## Test plan
- Lone fetch, LATENCY=1, `i_addr`=0x0, with `dmem` word 0 = 0x20010005 → `i_ack` 2 cycles after the request cycle, `i_rdata`=0x20010005; `d_ack` stays 0.
- Store then load, LATENCY=3: `d_addr`=0x2000, `d_wdata`=0x0000000D, `d_we`=1 → `mem_we` high for exactly 1 cycle and `d_ack` 4 cycles after the request. A following load of 0x2000 returns 0x0000000D.
- Byte load with sign extend: `d_addr`=0x2003, `d_byte`=1, `d_sext`=1, memory byte 0xF0 → `d_rdata`=0xFFFFFFF0.
- Both requests held continuously for 4 grants:
  - fixed priority: D, D, D, D; fetch never acked
  - with `MEM_ARB_RR_EN`: D, I, D, I
- Reset driven to 0 during BUSY of a store to 0x2004 (old value 0x1) → `mem_*` go to 0 immediately, location 0x2004 stays 0x1, no ack. After release, the still-held request completes normally.
